// File: rtl/pe_result_drain_pkg.sv
// rtl/pe_result_drain_pkg.sv - shared state encoding and drain-size helpers for pe_result_drain
package pe_result_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } drain_state_t;

    // Words held by each result FIFO for one complete layer pass.
    function automatic int calc_wpf(input int n, input int hout, input int wh, input int iw);
        return n / wh * hout / iw;
    endfunction

    // Words drained across all result FIFOs for one layer pass.
    function automatic int calc_total(input int n, input int hout, input int wh, input int iw);
        return wh * calc_wpf(n, hout, wh, iw);
    endfunction

endpackage

// File: rtl/pe_drain_skid.sv
// rtl/pe_drain_skid.sv - 2-entry valid/ready skid buffer with registered outputs
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   in_tvalid/in_tready    upstream handshake, in_tdata payload
//   out_tvalid/out_tready  downstream handshake, out_tdata payload
//   count                  current occupancy (0..2)
module pe_drain_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic [WIDTH-1:0] in_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [WIDTH-1:0] out_tdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             push;
    logic             pop;

    // A full buffer can still take a word in the cycle it hands one out.
    assign in_tready  = (cnt != 2'd2) || out_tready;
    assign out_tvalid = (cnt != 2'd0);
    assign out_tdata  = mem[rd_ptr];
    assign count      = cnt;
    assign push       = in_tvalid && in_tready;
    assign pop        = out_tvalid && out_tready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_tdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pe_result_drain.sv
// rtl/pe_result_drain.sv - drains PE result FIFOs into feature memory with optional ReLU
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   data_valid                upstream FIFOs hold a complete layer pass
//   fifo_dout                 per-FIFO read data, valid one cycle after fifo_rden
//   fifo_rden                 one-hot per-FIFO read strobe
//   row_rom_ready             drain ready (high in ARM, DRAIN, FLUSH)
//   base_addr                 start address, sampled on entering DRAIN
//   wr_valid/wr_ready         feature-memory write handshake
//   wr_addr, wr_data          write address and word (element 0 in LSBs)
//   done                      one-cycle pulse once every word has been written
module pe_result_drain
    import pe_result_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int HOUT       = 56,
    parameter int N          = 256,
    parameter int Wh         = 2,
    parameter int Iw         = 7,
    parameter int RELU_EN    = 1,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  data_valid,
    input  logic [Wh-1:0][Iw-1:0][DATA_WIDTH-1:0] fifo_dout,
    output logic [Wh-1:0]                         fifo_rden,
    output logic                                  row_rom_ready,
    input  logic [ADDR_WIDTH-1:0]                 base_addr,
    output logic                                  wr_valid,
    input  logic                                  wr_ready,
    output logic [ADDR_WIDTH-1:0]                 wr_addr,
    output logic [Iw*DATA_WIDTH-1:0]              wr_data,
    output logic                                  done
);

    localparam int TOTAL  = calc_total(N, HOUT, Wh, Iw);
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int SEL_W  = (Wh > 1) ? $clog2(Wh) : 1;
    localparam int WORD_W = Iw * DATA_WIDTH;
    localparam int SKID_W = ADDR_WIDTH + WORD_W;

    drain_state_t          state;
    drain_state_t          state_nxt;
    logic [CNT_W-1:0]      issued;
    logic [SEL_W-1:0]      rd_sel;
    logic [SEL_W-1:0]      pend_sel;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic                  pend;
    logic                  rd_en;
    logic [1:0]            skid_count;
    logic [1:0]            occ_after_pop;
    logic                  skid_pop;
    logic                  skid_in_ready;
    logic [WORD_W-1:0]     cap_word;
    logic [SKID_W-1:0]     skid_out;

    // Occupancy is taken after this cycle's write so a full-rate stream
    // (one word leaving while one is in flight) keeps reading every cycle.
    assign skid_pop      = wr_valid && wr_ready;
    assign occ_after_pop = skid_count - {1'b0, skid_pop};

    assign rd_en = (state == ST_DRAIN) && data_valid &&
                   (issued < CNT_W'(TOTAL)) && skid_in_ready &&
                   (({1'b0, occ_after_pop} + {2'b00, pend}) < 3'd2);

    assign row_rom_ready = (state == ST_ARM) || (state == ST_DRAIN) || (state == ST_FLUSH);
    assign done          = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = ST_ARM;
            ST_ARM:   if (data_valid) state_nxt = ST_DRAIN;
            ST_DRAIN: if (issued == CNT_W'(TOTAL)) state_nxt = ST_FLUSH;
            ST_FLUSH: if ((skid_count == 2'd0) && !pend) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_ARM;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_rden = '0;
        if (rd_en) begin
            fifo_rden[rd_sel] = 1'b1;
        end
    end

    // Elements are signed; the sign bit alone decides the clamp.
    always_comb begin
        cap_word = '0;
        for (int i = 0; i < Iw; i++) begin
            if ((RELU_EN != 0) && fifo_dout[pend_sel][i][DATA_WIDTH-1]) begin
                cap_word[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else begin
                cap_word[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout[pend_sel][i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            issued    <= '0;
            rd_sel    <= '0;
            pend_sel  <= '0;
            next_addr <= '0;
            pend_addr <= '0;
            pend      <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= rd_en;
            if ((state == ST_ARM) && data_valid) begin
                issued    <= '0;
                rd_sel    <= '0;
                next_addr <= base_addr;
            end else if (rd_en) begin
                issued    <= issued + CNT_W'(1);
                rd_sel    <= (rd_sel == SEL_W'(Wh - 1)) ? '0 : rd_sel + SEL_W'(1);
                next_addr <= next_addr + ADDR_WIDTH'(1);
                pend_sel  <= rd_sel;
                pend_addr <= next_addr;
            end
        end
    end

    pe_drain_skid #(
        .WIDTH (SKID_W)
    ) u_skid (
        .clk        (clk),
        .rstn       (rstn),
        .in_tvalid  (pend),
        .in_tready  (skid_in_ready),
        .in_tdata   ({pend_addr, cap_word}),
        .out_tvalid (wr_valid),
        .out_tready (wr_ready),
        .out_tdata  (skid_out),
        .count      (skid_count)
    );

    assign wr_addr = skid_out[SKID_W-1:WORD_W];
    assign wr_data = skid_out[WORD_W-1:0];

endmodule

// File: tb/tb_pe_result_drain.sv
// tb/tb_pe_result_drain.sv - self-checking bench for pe_result_drain
module tb_pe_result_drain;

    localparam int DW    = 8;
    localparam int HOUT  = 14;
    localparam int NCH   = 4;
    localparam int WH    = 2;
    localparam int IW    = 7;
    localparam int AW    = 16;
    localparam int TOTAL = 8;

    typedef struct {
        logic [AW-1:0] base;
        int            bp_at;
        int            bp_len;
        int            gap_at;
        int            gap_len;
        int            exp_writes;
        logic [AW-1:0] exp_last;
    } vec_t;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [IW*DW-1:0] relu;
        logic [IW*DW-1:0] raw;
    } exp_t;

    logic clk = 1'b0;
    logic rstn, data_valid, wr_ready, fifo_clr;
    logic [WH-1:0][IW-1:0][DW-1:0] fifo_dout = '0;
    logic [WH-1:0]    fifo_rden, fifo_rden_nr;
    logic             row_rom_ready, row_rom_ready_nr;
    logic [AW-1:0]    base_addr, wr_addr, wr_addr_nr;
    logic             wr_valid, wr_valid_nr, done, done_nr;
    logic [IW*DW-1:0] wr_data, wr_data_nr;

    int   checks = 0;
    int   errors = 0;
    int   seed = 0;
    int   fptr [WH];
    exp_t sbq [$];
    vec_t vecs [4];
    logic [DW-1:0] first_relu, first_raw;

    always #5 clk = ~clk;

    pe_result_drain #(
        .DATA_WIDTH(DW), .HOUT(HOUT), .N(NCH), .Wh(WH), .Iw(IW), .RELU_EN(1), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rstn(rstn), .data_valid(data_valid), .fifo_dout(fifo_dout),
        .fifo_rden(fifo_rden), .row_rom_ready(row_rom_ready), .base_addr(base_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done)
    );

    pe_result_drain #(
        .DATA_WIDTH(DW), .HOUT(HOUT), .N(NCH), .Wh(WH), .Iw(IW), .RELU_EN(0), .ADDR_WIDTH(AW)
    ) dut_nr (
        .clk(clk), .rstn(rstn), .data_valid(data_valid), .fifo_dout(fifo_dout),
        .fifo_rden(fifo_rden_nr), .row_rom_ready(row_rom_ready_nr), .base_addr(base_addr),
        .wr_valid(wr_valid_nr), .wr_ready(wr_ready), .wr_addr(wr_addr_nr), .wr_data(wr_data_nr),
        .done(done_nr)
    );

    function automatic logic [IW*DW-1:0] gen_word(input int s, input int f, input int j);
        logic [IW*DW-1:0] w;
        for (int e = 0; e < IW; e++) begin
            w[e*DW +: DW] = 8'((s * 37 + f * 71 + j * 13 + e * 29 + 3) & 255);
        end
        if (f == 0 && j == 0) w[DW-1:0] = 8'hFB;
        return w;
    endfunction

    function automatic logic [IW*DW-1:0] relu_word(input logic [IW*DW-1:0] w);
        logic [IW*DW-1:0] r;
        for (int e = 0; e < IW; e++) begin
            r[e*DW +: DW] = w[e*DW + DW - 1] ? 8'h00 : w[e*DW +: DW];
        end
        return r;
    endfunction

    // Upstream result FIFOs: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        for (int f = 0; f < WH; f++) begin
            if (fifo_clr) begin
                fptr[f] <= 0;
            end else if (fifo_rden[f]) begin
                fifo_dout[f] <= gen_word(seed, f, fptr[f]);
                fptr[f]      <= fptr[f] + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rden"}, fifo_rden, 0);
        chk({tag, "_row_rom_ready"}, row_rom_ready, 0);
        chk({tag, "_wr_valid"}, wr_valid, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_case(input vec_t v, input int id);
        int reads, writes, dones, rrr_low, maxout, gap_rden, post;
        logic held, finished;
        logic [AW-1:0] h_addr, last_addr;
        logic [IW*DW-1:0] h_data;
        exp_t e;
        reads = 0; writes = 0; dones = 0; rrr_low = 0; maxout = 0; gap_rden = 0; post = 0;
        held = 1'b0; finished = 1'b0; h_addr = '0; last_addr = '0; h_data = '0;
        seed = id;
        base_addr = v.base;
        sbq.delete();
        fifo_clr = 1'b1;
        @(posedge clk); #1;
        fifo_clr = 1'b0;
        for (int cyc = 0; cyc < 300 && post < 3; cyc++) begin
            data_valid = !finished && !(cyc >= v.gap_at && cyc < v.gap_at + v.gap_len);
            wr_ready   = !(cyc >= v.bp_at && cyc < v.bp_at + v.bp_len);
            @(negedge clk);
            if (reads - writes > maxout) maxout = reads - writes;
            if (fifo_rden != '0) begin
                if (!data_valid) gap_rden++;
                if (reads >= TOTAL) chk("over_read", reads, TOTAL - 1);
                chk("rden_order", fifo_rden, 64'(1) << (reads % WH));
                e.addr = v.base + AW'(reads);
                e.raw  = gen_word(id, reads % WH, reads / WH);
                e.relu = relu_word(e.raw);
                sbq.push_back(e);
                reads++;
            end
            if (held) begin
                chk("hold_valid", wr_valid, 1);
                chk("hold_addr", wr_addr, h_addr);
                chk("hold_data", wr_data, h_data);
            end
            held = 1'b0;
            if (wr_valid && wr_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data_relu", wr_data, e.relu);
                    chk("wr_data_raw", wr_data_nr, e.raw);
                end
                if (writes == 0) begin
                    first_relu = wr_data[DW-1:0];
                    first_raw  = wr_data_nr[DW-1:0];
                end
                writes++;
                last_addr = wr_addr;
            end else if (wr_valid) begin
                held   = 1'b1;
                h_addr = wr_addr;
                h_data = wr_data;
            end
            if (!row_rom_ready) rrr_low++;
            if (done) begin
                dones++;
                finished = 1'b1;
            end
            if (finished) post++;
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        wr_ready   = 1'b1;
        chk("write_count", writes, v.exp_writes);
        chk("last_addr", last_addr, v.exp_last);
        chk("done_pulses", dones, 1);
        chk("row_rom_ready_low_cycles", rrr_low, 1);
        chk("max_outstanding", (maxout <= 2) ? 2 : maxout, 2);
        chk("rden_in_gap", gap_rden, 0);
        chk("scoreboard_empty", sbq.size(), 0);
    endtask

    initial begin
        int w;
        vecs[0] = '{16'h0100, -1, 0, -1, 0, 8, 16'h0107};
        vecs[1] = '{16'h0040,  5, 10, -1, 0, 8, 16'h0047};
        vecs[2] = '{16'hFFFE, -1, 0, -1, 0, 8, 16'h0005};
        vecs[3] = '{16'h0500, -1, 0,  3, 4, 8, 16'h0507};

        rstn = 1'b0; data_valid = 1'b0; wr_ready = 1'b1; base_addr = '0; fifo_clr = 1'b0;
        first_relu = '0; first_raw = '0;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end

        for (int i = 0; i < 4; i++) begin
            run_case(vecs[i], i);
            if (i == 0) begin
                chk("relu_on_elem0", first_relu, 8'h00);
                chk("relu_off_elem0", first_raw, 8'hFB);
            end
        end

        // Reset in the middle of a drain, then a clean drain from a new base.
        seed = 5;
        base_addr = 16'h0200;
        fifo_clr = 1'b1;
        @(posedge clk); #1;
        fifo_clr = 1'b0;
        data_valid = 1'b1;
        wr_ready = 1'b1;
        w = 0;
        for (int c = 0; c < 40 && w < 3; c++) begin
            @(negedge clk);
            if (wr_valid && wr_ready) w++;
            @(posedge clk); #1;
        end
        chk("pre_reset_writes", w, 3);
        rstn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        data_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        run_case('{16'h0300, -1, 0, -1, 0, 8, 16'h0307}, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_result_drain.md
PE_RESULT_DRAIN -- requirements
Module: pe_result_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter HOUT, default 56, output rows per map.
REQ-003 SHALL have parameter N, default 256, output channels.
REQ-004 SHALL have parameter Wh, default 2, number of result FIFOs.
REQ-005 SHALL have parameter Iw, default 7, elements per FIFO word.
REQ-006 SHALL have parameter RELU_EN, default 1, clamps negative elements to 0 when set.
REQ-007 SHALL have parameter ADDR_WIDTH, default 16, feature-memory address width.
REQ-008 SHALL have port clk, input, 1, clock.
REQ-009 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-010 SHALL have port data_valid, input, 1, upstream result FIFOs hold a complete layer pass.
REQ-011 SHALL have port fifo_dout, input, [Wh][Iw][DATA_WIDTH], signed FIFO read data, valid 1 cycle after the matching rden.
REQ-012 SHALL have port fifo_rden, output, Wh, one-hot per-FIFO read strobe.
REQ-013 SHALL have port row_rom_ready, output, 1, drain ready; upstream read-enable gating.
REQ-014 SHALL have port base_addr, input, ADDR_WIDTH, start address, sampled on entering DRAIN.
REQ-015 SHALL have ports wr_valid/wr_ready, output/input, 1 each, feature-memory write handshake.
REQ-016 SHALL have port wr_addr, output, ADDR_WIDTH, write address.
REQ-017 SHALL have port wr_data, output, Iw*DATA_WIDTH, write data, element 0 in LSBs.
REQ-018 SHALL have port done, output, 1, one-cycle pulse after the last accepted write.

Function
REQ-019 SHALL define WPF = N/Wh*HOUT/Iw words per FIFO and TOTAL = Wh*WPF.
REQ-020 SHALL implement states IDLE, ARM, DRAIN, FLUSH, DONE.
REQ-021 SHALL transition IDLE->ARM unconditionally; ARM->DRAIN when data_valid=1; DRAIN->FLUSH when issued count reaches TOTAL; FLUSH->DONE when the skid buffer is empty; DONE->ARM after one cycle.
REQ-022 SHALL drive row_rom_ready=1 in ARM, DRAIN, FLUSH and 0 in IDLE and DONE; it SHALL NOT drop during a drain regardless of wr_ready.
REQ-023 SHALL issue reads in interleaved order FIFO 0,1,..,Wh-1,0,1,.. with at most one fifo_rden bit high per cycle.
REQ-024 SHALL assert a read only in DRAIN with data_valid=1, issued<TOTAL, and skid occupancy plus in-flight reads below 2.
REQ-025 SHALL capture fifo_dout of the read FIFO exactly one cycle after its rden.
REQ-026 SHALL apply ReLU per element when RELU_EN=1, otherwise pass through unchanged.
REQ-027 SHALL assign wr_addr = base_addr + k for the k-th read (k=0..TOTAL-1), modulo 2^ADDR_WIDTH.
REQ-028 SHALL hold wr_valid, wr_addr, wr_data stable while wr_valid=1 and wr_ready=0.
REQ-029 SHALL give a read-to-wr_valid latency of 2 cycles with wr_ready=1 and sustain 1 word/cycle.
REQ-030 SHALL pulse done exactly once per drain, in the DONE state.
REQ-031 SHALL, if data_valid falls in DRAIN, stop issuing reads, hold counters, and resume when it rises.

Reset
REQ-032 SHALL, on rstn=0, enter IDLE and clear counters and the skid buffer; fifo_rden=0, row_rom_ready=0, wr_valid=0, wr_addr=0, wr_data=0, done=0.
REQ-033 SHALL discard in-flight data on reset mid-drain and restart from ARM.

Structure
REQ-034 SHALL place the state encoding and the WPF/TOTAL derivation function in a shared package.
REQ-035 SHALL use one sub-module, pe_drain_skid, a 2-entry valid/ready skid buffer of width ADDR_WIDTH+Iw*DATA_WIDTH.

Verification
All scenarios use N=4, HOUT=14, Wh=2, Iw=7, so WPF=4 and TOTAL=8.
REQ-036 SHALL cover a basic drain: data_valid=1, wr_ready=1, base_addr=0x100 -> rden order 01,10,01,10...; 8 writes at 0x100..0x107; done pulses once; row_rom_ready drops for 1 cycle.
REQ-037 SHALL cover ReLU: element value -5 (0xFB) -> written as 0x00 with RELU_EN=1 and as 0xFB with RELU_EN=0.
REQ-038 SHALL cover back-pressure: wr_ready=0 for 10 cycles mid-drain -> at most 2 reads outstanding, output held stable, no data lost, row_rom_ready stays 1.
REQ-039 SHALL cover address wrap: base_addr=0xFFFE -> addresses FFFE, FFFF, 0000..0005.
REQ-040 SHALL cover reset mid-drain: rstn low after 3 writes -> all outputs at reset values; next drain restarts at base_addr.
REQ-041 SHALL cover a data_valid gap: data_valid low for 4 cycles in DRAIN -> no rden during the gap, order and addresses continue correctly.
